// File: rtl/frontend_pkg.sv
// Shared front-end definitions for the fetch/decode boundary.
//   INSTR_W      : instruction word width
//   PC_W         : PC width carried by fetch_lane_t
//   fetch_lane_t : one fetch lane {valid, pc, instr}
//   popcount     : number of set bits in a lane mask (up to 64 lanes)
package frontend_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_lane_t;

  function automatic int unsigned popcount(input logic [63:0] mask);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      n = n + 32'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue.
//   in_valid/in_pc/in_instr : fetch group offered to the queue
//   in_ready                : queue can take a full fetch group
//   out_valid/out_pc/out_instr : lanes presented to decode
//   out_ready               : decode takes every presented lane
//   count                   : queue occupancy
// Modports: slave = queue side, master = fetch/decode side.
interface fetch_queue_if
  import frontend_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 4
) ();

  logic [FETCH_W-1:0]         in_valid;
  logic [FETCH_W*XLEN-1:0]    in_pc;
  logic [FETCH_W*INSTR_W-1:0] in_instr;
  logic                       in_ready;
  logic [DEC_W-1:0]           out_valid;
  logic [DEC_W*XLEN-1:0]      out_pc;
  logic [DEC_W*INSTR_W-1:0]   out_instr;
  logic                       out_ready;
  logic [CNT_W-1:0]           count;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fq_compact.sv
// Combinational lane compaction: valid input lanes are packed, in
// ascending lane order, into output lanes starting at lane 0.
//   in_valid/in_pc/in_instr : raw fetch lanes
//   c_valid/c_pc/c_instr    : compacted lanes (contiguous valid, zero elsewhere)
//   n_valid                 : number of valid lanes
module fq_compact
  import frontend_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int XLEN    = 32,
  localparam int N_W    = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]         in_valid,
  input  logic [FETCH_W*XLEN-1:0]    in_pc,
  input  logic [FETCH_W*INSTR_W-1:0] in_instr,
  output logic [FETCH_W-1:0]         c_valid,
  output logic [FETCH_W*XLEN-1:0]    c_pc,
  output logic [FETCH_W*INSTR_W-1:0] c_instr,
  output logic [N_W-1:0]             n_valid
);

  // rank[i] = number of valid lanes below lane i = destination slot of lane i
  logic [N_W-1:0] rank [FETCH_W];

  always_comb begin
    rank[0] = '0;
    for (int unsigned i = 1; i < FETCH_W; i++) begin
      rank[i] = rank[i-1] + N_W'(in_valid[i-1]);
    end
  end

  always_comb begin
    c_valid = '0;
    c_pc    = '0;
    c_instr = '0;
    for (int unsigned j = 0; j < FETCH_W; j++) begin
      for (int unsigned i = j; i < FETCH_W; i++) begin
        if (in_valid[i] && (rank[i] == N_W'(j))) begin
          c_valid[j]                     = 1'b1;
          c_pc[j*XLEN +: XLEN]           = in_pc[i*XLEN +: XLEN];
          c_instr[j*INSTR_W +: INSTR_W]  = in_instr[i*INSTR_W +: INSTR_W];
        end
      end
    end
  end

  assign n_valid = N_W'(popcount(64'(in_valid)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Decouples fetch and decode
// lane counts, compacts invalid fetch lanes on entry and absorbs decode
// back-pressure. A flush discards all contents.
//   clk, reset : clock, synchronous active-high reset
//   flush      : redirect flush, beats enqueue/dequeue that cycle
//   bus        : fetch_queue_if slave (fetch group in, decode lanes out, count)
// Optional: define FETCH_QUEUE_BYPASS_EN for 0-cycle bypass when empty.
module fetch_queue
  import frontend_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  input logic flush,
  fetch_queue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int N_W   = $clog2(FETCH_W + 1);

  logic [XLEN-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic [FETCH_W-1:0]         c_valid;
  logic [FETCH_W*XLEN-1:0]    c_pc;
  logic [FETCH_W*INSTR_W-1:0] c_instr;
  logic [N_W-1:0]             n_in;
  logic [CNT_W-1:0]           n_in_c, n_skip, n_enq, n_deq;
  logic                       do_enq;

  logic [DEC_W-1:0]         q_valid;
  logic [DEC_W*XLEN-1:0]    q_pc;
  logic [DEC_W*INSTR_W-1:0] q_instr;
  logic [IDX_W-1:0]         rd_idx [DEC_W];
  logic [IDX_W-1:0]         wr_idx [FETCH_W];
  logic [FETCH_W-1:0]       wr_en;

  fq_compact #(.FETCH_W(FETCH_W), .XLEN(XLEN)) u_compact (
    .in_valid (bus.in_valid),
    .in_pc    (bus.in_pc),
    .in_instr (bus.in_instr),
    .c_valid  (c_valid),
    .c_pc     (c_pc),
    .c_instr  (c_instr),
    .n_valid  (n_in)
  );

  // Wrap-bit pointers: the difference is the occupancy, DEPTH when full.
  assign count     = CNT_W'(tail - head);
  assign bus.count = count;
  assign bus.in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
  assign n_in_c    = CNT_W'(n_in);

  always_comb begin
    q_valid = '0;
    q_pc    = '0;
    q_instr = '0;
    for (int unsigned i = 0; i < DEC_W; i++) begin
      rd_idx[i] = head[IDX_W-1:0] + IDX_W'(i);
      if (CNT_W'(i) < count) begin
        q_valid[i]                     = 1'b1;
        q_pc[i*XLEN +: XLEN]           = mem_pc[rd_idx[i]];
        q_instr[i*INSTR_W +: INSTR_W]  = mem_instr[rd_idx[i]];
      end
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BX = FETCH_W + DEC_W;
  logic                   byp_active;
  logic [BX-1:0]          byp_valid;
  logic [BX*XLEN-1:0]     byp_pc;
  logic [BX*INSTR_W-1:0]  byp_instr;

  assign byp_active = (count == '0) && !flush && !reset;
  assign byp_valid  = BX'(c_valid);
  assign byp_pc     = (BX*XLEN)'(c_pc);
  assign byp_instr  = (BX*INSTR_W)'(c_instr);
  // Lanes taken by decode straight from the input are not written.
  assign n_skip = (byp_active && bus.out_ready)
                ? ((n_in_c < CNT_W'(DEC_W)) ? n_in_c : CNT_W'(DEC_W)) : '0;

  always_comb begin
    bus.out_valid = q_valid;
    bus.out_pc    = q_pc;
    bus.out_instr = q_instr;
    if (byp_active) begin
      bus.out_valid = byp_valid[DEC_W-1:0];
      bus.out_pc    = byp_pc[DEC_W*XLEN-1:0];
      bus.out_instr = byp_instr[DEC_W*INSTR_W-1:0];
    end
  end
`else
  assign n_skip        = '0;
  assign bus.out_valid = q_valid;
  assign bus.out_pc    = q_pc;
  assign bus.out_instr = q_instr;
`endif

  assign do_enq = bus.in_ready && (|bus.in_valid);
  assign n_enq  = do_enq ? (n_in_c - n_skip) : '0;
  assign n_deq  = bus.out_ready ? CNT_W'(popcount(64'(q_valid))) : '0;

  always_comb begin
    wr_en = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      wr_idx[k] = tail[IDX_W-1:0] + IDX_W'(k) - IDX_W'(n_skip);
      wr_en[k]  = do_enq && c_valid[k] && (CNT_W'(k) >= n_skip);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        if (wr_en[k]) begin
          mem_pc[wr_idx[k]]    <= c_pc[k*XLEN +: XLEN];
          mem_instr[wr_idx[k]] <= c_instr[k*INSTR_W +: INSTR_W];
        end
      end
      tail <= tail + PTR_W'(n_enq);
      head <= head + PTR_W'(n_deq);
    end
  end

endmodule
